// File: rtl/data_ram_ctrl.sv
// Data-memory controller: word-addressed internal RAM behind a fixed wait-state
// access sequence, with stall request, one-cycle ack and out-of-range error.
module data_ram_ctrl #(
  parameter int MEM_AW = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t      state;
  logic [3:0]  cnt;
  logic        req_we;
  logic [31:2] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;

  logic [31:0]       mem [0:2**MEM_AW-1];
  logic [MEM_AW-1:0] word;
  logic              oor;
  logic              unused_addr_lsb;

  assign word            = req_addr[MEM_AW+1:2];
  assign oor             = |req_addr[31:MEM_AW+2];
  assign unused_addr_lsb = ^addr_i[1:0];

  assign stallreq_o = (state == S_IDLE && ce_i) || state == S_WAIT || state == S_ACCESS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      data_o   <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_sel  <= '0;
      req_data <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ce_i) begin
            req_we   <= we_i;
            req_addr <= addr_i[31:2];
            req_sel  <= sel_i;
            req_data <= data_i;
            cnt      <= WAIT_CNT;
            state    <= (WAIT > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) state <= S_ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACCESS: begin
          // Writes and out-of-range accesses both return zero data.
          if (req_we || oor) data_o <= '0;
          else               data_o <= mem[word];
          ack_o <= 1'b1;
          err_o <= oor;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared; rst only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && req_we && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (req_sel[i]) mem[word][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: table-driven transactions on a WAIT=2 instance with an
// ack scoreboard, plus hand sequences for back-to-back, reset-abort and WAIT=0.
module tb_data_ram_ctrl;
  localparam int WAIT_T = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce, we;
  logic [31:0] addr, data_in, data_out;
  logic [3:0]  sel;
  logic        ack, err, stall;

  logic        ce0, we0;
  logic [31:0] addr0, data0_in, data0_out;
  logic [3:0]  sel0;
  logic        ack0, err0, stall0;

  data_ram_ctrl #(.MEM_AW(10), .WAIT(WAIT_T)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
    .data_i(data_in), .data_o(data_out), .ack_o(ack), .err_o(err), .stallreq_o(stall)
  );

  data_ram_ctrl #(.MEM_AW(10), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0), .sel_i(sel0),
    .data_i(data0_in), .data_o(data0_out), .ack_o(ack0), .err_o(err0), .stallreq_o(stall0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          issue;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;
  vec_t vecs[19];

  // Scoreboard: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t x;
    if (ack === 1'b1) begin
      if (q.size() == 0) begin
        check_bit("ack_without_request", ack, 1'b0);
      end else begin
        x = q.pop_front();
        check_word("ack_data", data_out, x.d);
        check_bit("ack_err", err, x.e);
        check_word("ack_latency", 32'(cyc - x.issue), 32'(WAIT_T + 2));
      end
    end else if (err === 1'b1) begin
      check_bit("err_without_ack", err, 1'b0);
    end
  end

  task automatic txn(input vec_t v);
    exp_t x;
    int   n;
    @(negedge clk);
    #1;
    ce = 1'b1; we = v.we; addr = v.addr; sel = v.sel; data_in = v.wdata;
    x.d = v.exp_d; x.e = v.exp_e; x.issue = cyc;
    q.push_back(x);
    #1 check_bit("stall_cycle0", stall, 1'b1);
    @(posedge clk);
    #1;
    ce = 1'b0; we = ~v.we; addr = $urandom; sel = 4'($urandom); data_in = $urandom;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      if (q.size() != 0) check_bit("stall_busy", stall, 1'b1);
      n++;
    end
    if (q.size() != 0) begin
      check_word("ack_timeout_pending", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    @(negedge clk);
    #1;
    ce0 = 1'b1; we0 = w; addr0 = a; data0_in = d; sel0 = 4'hF;
    #1;
    check_bit("w0_stall_c0", stall0, 1'b1);
    check_bit("w0_ack_c0", ack0, 1'b0);
    @(posedge clk);
    #1;
    ce0 = 1'b0; we0 = ~w; addr0 = ~a; data0_in = ~d;
    @(negedge clk);
    check_bit("w0_stall_c1", stall0, 1'b1);
    check_bit("w0_ack_c1", ack0, 1'b0);
    @(negedge clk);
    check_bit("w0_ack_c2", ack0, 1'b1);
    check_bit("w0_err_c2", err0, 1'b0);
    check_bit("w0_stall_c2", stall0, 1'b0);
    check_word("w0_data_c2", data0_out, exp);
  endtask

  initial begin
    exp_t x;
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'h4, 32'h00AB_0000, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'h12AB_5678, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,         32'h1122_3344, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0014, 4'h9, 32'hAABB_CCDD, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,         32'hAA22_33DD, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0FFF, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,         32'h0, 1'b1};
    vecs[15] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h12AB_5678, 1'b0};
    vecs[16] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         32'h0, 1'b1};
    vecs[17] = '{1'b1, 32'h0000_0020, 4'hF, 32'h0102_0304, 32'h0, 1'b0};
    vecs[18] = '{1'b0, 32'h0000_0023, 4'h0, 32'h0,         32'h0102_0304, 1'b0};

    rst = 1'b1;
    ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_in = '0;
    ce0 = 1'b0; we0 = 1'b0; addr0 = '0; sel0 = '0; data0_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_word("reset_data", data_out, 32'h0);
    check_bit("reset_ack", ack, 1'b0);
    check_bit("reset_err", err, 1'b0);
    check_bit("reset_stall", stall, 1'b0);
    check_bit("reset_stall_w0", stall0, 1'b0);
    check_word("reset_data_w0", data0_out, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) txn(vecs[i]);

    // ce held across two reads: acks on cycles 4 and 9, stall drops only then.
    @(negedge clk);
    #1;
    ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'h0;
    x.d = 32'h12AB_5678; x.e = 1'b0; x.issue = cyc;
    q.push_back(x);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      check_bit("b2b_stall", stall, (k != 4 && k != 9));
      if (k == 5) begin
        x.issue = cyc;
        q.push_back(x);
      end
    end
    ce = 1'b0;
    @(negedge clk);
    #2;
    check_bit("b2b_idle_stall", stall, 1'b0);
    check_word("b2b_pending", 32'(q.size()), 32'd0);

    // Reset landing on the ACCESS edge of a write aborts it.
    @(negedge clk);
    #1;
    ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; data_in = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ce = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_bit("rst_access_stall", stall, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_bit("rst_after_ack", ack, 1'b0);
    check_bit("rst_after_stall", stall, 1'b0);
    check_word("rst_after_data", data_out, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_bit("rst_no_late_ack", ack, 1'b0);
    end
    txn('{1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h0102_0304, 1'b0});

    // WAIT=0 instance: two-cycle latency.
    txn0(1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 32'h0);
    txn0(1'b0, 32'h0000_0010, 32'h0, 32'h0BAD_CAFE);
    @(negedge clk);
    check_bit("w0_idle_stall", stall0, 1'b0);
    check_bit("w0_idle_ack", ack0, 1'b0);

    repeat (3) @(negedge clk);
    check_word("final_pending", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
